// File: rtl/frame_copy_sched_if.sv
// ---------------------------------------------------------------------------
// frame_copy_sched_if
//
// Copy handshake between the copy sequencer and the dual-port frame buffer,
// in the read/VGA clock domain.
//
// Signals:
//   buf_r_rd    level copy request, driven by the sequencer and held
//               high for the whole copy
//   buf_r_done  copy-done flag, driven by the buffer; idles high, falls
//               when the buffer accepts a request, rises when the copy ends
//
// Modports:
//   master  sequencer side (drives buf_r_rd)
//   slave   frame buffer side (drives buf_r_done)
// ---------------------------------------------------------------------------
interface frame_copy_sched_if;
  logic buf_r_rd;
  logic buf_r_done;

  modport master (
    output buf_r_rd,
    input  buf_r_done
  );

  modport slave (
    input  buf_r_rd,
    output buf_r_done
  );
endinterface

// File: rtl/frame_copy_sched.sv
// ---------------------------------------------------------------------------
// frame_copy_sched
//
// Sequencer for the frame buffer's A-to-B copy, in the read/VGA clock
// domain. The sequencer waits for a finished camera frame and then for
// vertical blanking. It then raises the buffer's level copy request and
// follows the buffer's done flag until the copy completes. It also counts
// completed copies and dropped frames, and it flags a stalled buffer.
//
// Parameters:
//   START_WAIT   cycles allowed in START for buf_r_done to fall
//   GAP_CYC      cycles buf_r_rd stays low after a copy (>= 2, because the
//                buffer edge-detects the request through two flops)
//   TIMEOUT_CYC  cycles allowed in COPY; only used with the macro below
//
// Ports:
//   r_clk           clock, read/VGA domain
//   rst             asynchronous active-high reset
//   enable          allows new copies to arm or start
//   cam_frame_done  one-cycle frame-complete pulse, already in r_clk domain
//   vga_vblank      high during vertical blanking
//   buf_bus         copy handshake to the frame buffer (master modport)
//   copy_busy       high while in START or COPY
//   frame_cnt       completed copies, wraps
//   drop_cnt        dropped frames, saturates at 255
//   err_timeout     sticky stall flag, cleared only by rst
//   state_dbg       current state encoding
//
// Build option:
//   FRAME_COPY_SCHED_TIMEOUT_EN  when defined, COPY gives up after
//   TIMEOUT_CYC cycles without buf_r_done rising. When undefined, COPY waits
//   indefinitely and the COPY timeout counter is not built.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module frame_copy_sched #(
  parameter int START_WAIT  = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 70000
) (
  input  logic                      r_clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      cam_frame_done,
  input  logic                      vga_vblank,
  frame_copy_sched_if.master        buf_bus,
  output logic                      copy_busy,
  output logic [15:0]               frame_cnt,
  output logic [7:0]                drop_cnt,
  output logic                      err_timeout,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    START = 3'd2,
    COPY  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // The state counter restarts at zero on every state entry. A state that
  // exits on "count == N-1" therefore stays for exactly N cycles.
  localparam logic [16:0] START_LAST = 17'(START_WAIT - 1);
  localparam logic [16:0] GAP_LAST   = 17'(GAP_CYC - 1);
`ifdef FRAME_COPY_SCHED_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYC - 1);
`else
  // TIMEOUT_CYC has no consumer when the COPY timeout is compiled out.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  state_t      state;
  state_t      state_nx;
  logic [16:0] cnt;
  logic [16:0] cnt_nx;
  logic        cnt_run;
  logic        rd_q;
  logic        rd_nx;
  logic        busy_nx;
  logic        frame_inc;
  logic        err_set;
  logic        drop_evt;

  // Next-state and next-output decode. enable is only looked at in IDLE and
  // ARMED. After the request is raised, the copy always runs to completion,
  // because dropping buf_r_rd mid-copy would freeze the buffer.
  always_comb begin
    state_nx  = state;
    rd_nx     = rd_q;
    frame_inc = 1'b0;
    err_set   = 1'b0;
    cnt_run   = 1'b0;

    case (state)
      IDLE: begin
        rd_nx = 1'b0;
        if (enable && cam_frame_done) begin
          state_nx = ARMED;
        end
      end

      ARMED: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (vga_vblank) begin
          state_nx = START;
          rd_nx    = 1'b1;
        end
      end

      START: begin
        cnt_run = 1'b1;
        if (!buf_bus.buf_r_done) begin
          state_nx = COPY;
        end else if (cnt == START_LAST) begin
          state_nx = GAP;
          rd_nx    = 1'b0;
          err_set  = 1'b1;
        end
      end

      COPY: begin
        if (buf_bus.buf_r_done) begin
          state_nx  = GAP;
          rd_nx     = 1'b0;
          frame_inc = 1'b1;
        end
`ifdef FRAME_COPY_SCHED_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nx = GAP;
          rd_nx    = 1'b0;
          err_set  = 1'b1;
        end
        cnt_run = 1'b1;
`endif
      end

      GAP: begin
        cnt_run = 1'b1;
        rd_nx   = 1'b0;
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        rd_nx    = 1'b0;
      end
    endcase

    if (state_nx != state) begin
      cnt_nx = 17'd0;
    end else if (cnt_run) begin
      cnt_nx = cnt + 17'd1;
    end else begin
      cnt_nx = cnt;
    end

    // Every frame that finishes outside IDLE is lost. This includes frames
    // on transition cycles, and a frame on the GAP-to-IDLE cycle does not arm.
    drop_evt = cam_frame_done && (state != IDLE);

    busy_nx = (state_nx == START) || (state_nx == COPY);
  end

  // State, request and counters. Reset returns to IDLE at once with the
  // request low. The buffer itself has no reset.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 17'd0;
      rd_q        <= 1'b0;
      copy_busy   <= 1'b0;
      frame_cnt   <= 16'd0;
      drop_cnt    <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rd_q      <= rd_nx;
      copy_busy <= busy_nx;
      if (frame_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop_evt && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if (err_set) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign buf_bus.buf_r_rd = rd_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_frame_copy_sched.sv
// ---------------------------------------------------------------------------
// tb_frame_copy_sched
//
// Directed bench for frame_copy_sched. A small behavioural buffer model
// answers the copy request. It drops done three edges after rd rises and
// raises it copy_len edges later; it can also be set to never drop done or
// to never raise it again. The design runs with START_WAIT=8, GAP_CYC=4 and
// TIMEOUT_CYC=100.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_copy_sched;

  logic        r_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cam_frame_done;
  logic        vga_vblank;
  logic        copy_busy;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic        err_timeout;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // buffer model controls: 0 normal, 1 never acknowledges, 2 never finishes
  int   buf_mode = 0;
  int   copy_len = 40;
  int   rd_age   = 0;
  logic buf_done_q = 1'b1;
  int   rd_rises = 0;
  logic rd_seen  = 1'b0;

  frame_copy_sched_if bif();

  frame_copy_sched #(
    .START_WAIT  (8),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .r_clk          (r_clk),
    .rst            (rst),
    .enable         (enable),
    .cam_frame_done (cam_frame_done),
    .vga_vblank     (vga_vblank),
    .buf_bus        (bif),
    .copy_busy      (copy_busy),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt),
    .err_timeout    (err_timeout),
    .state_dbg      (state_dbg)
  );

  always #5 r_clk = ~r_clk;

  assign bif.buf_r_done = buf_done_q;

  always @(posedge r_clk) begin
    if (!bif.buf_r_rd) begin
      rd_age     <= 0;
      buf_done_q <= 1'b1;
    end else begin
      rd_age <= rd_age + 1;
      if (buf_mode != 1 && rd_age == 2) buf_done_q <= 1'b0;
      else if (buf_mode == 0 && rd_age == 2 + copy_len) buf_done_q <= 1'b1;
    end
  end

  always @(negedge r_clk) begin
    if (bif.buf_r_rd && !rd_seen) rd_rises = rd_rises + 1;
    rd_seen = bif.buf_r_rd;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    cam_frame_done = 1'b1;
    step(1);
    cam_frame_done = 1'b0;
  endtask

  task automatic pulse_vblank();
    vga_vblank = 1'b1;
    step(1);
    vga_vblank = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cam_frame_done = 1'b0; vga_vblank = 1'b0;
    step(3);
    n_checks++; if (bif.buf_r_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd: got %0d expected 0", bif.buf_r_rd); end
    n_checks++; if (copy_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0d expected 0", copy_busy); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %0d expected 0", err_timeout); end
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state_dbg); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_nominal_copy();
    $display("[TB] nominal copy");
    buf_mode = 0; copy_len = 40; enable = 1'b1;
    pulse_frame();
    n_checks++; if (state_dbg !== 3'd1) begin n_fail++; $display("[TB] FAIL nom_armed: got %0d expected 1", state_dbg); end
    step(10);
    n_checks++; if (bif.buf_r_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL nom_rd_before_vblank: got %0d expected 0", bif.buf_r_rd); end
    pulse_vblank();
    n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("[TB] FAIL nom_start: got %0d expected 2", state_dbg); end
    n_checks++; if (bif.buf_r_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL nom_rd_rise: got %0d expected 1", bif.buf_r_rd); end
    n_checks++; if (copy_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL nom_busy_start: got %0d expected 1", copy_busy); end
    step(3);
    n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("[TB] FAIL nom_still_start: got %0d expected 2", state_dbg); end
    step(1);
    n_checks++; if (state_dbg !== 3'd3) begin n_fail++; $display("[TB] FAIL nom_copy: got %0d expected 3", state_dbg); end
    step(39);
    n_checks++; if (state_dbg !== 3'd3 || bif.buf_r_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL nom_copy_hold: got state %0d rd %0d expected 3/1", state_dbg, bif.buf_r_rd); end
    step(1);
    n_checks++; if (state_dbg !== 3'd4 || bif.buf_r_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL nom_gap: got state %0d rd %0d expected 4/0", state_dbg, bif.buf_r_rd); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL nom_frame_cnt: got %0d expected 1", frame_cnt); end
    n_checks++; if (copy_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL nom_busy_gap: got %0d expected 0", copy_busy); end
    step(3);
    n_checks++; if (state_dbg !== 3'd4) begin n_fail++; $display("[TB] FAIL nom_gap_hold: got %0d expected 4", state_dbg); end
    step(1);
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("[TB] FAIL nom_idle: got %0d expected 0", state_dbg); end
    n_checks++; if (drop_cnt !== 8'd0 || err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL nom_drop_err: got drop %0d err %0d expected 0/0", drop_cnt, err_timeout); end
  endtask

  task automatic test_frame_during_copy();
    int r0;
    $display("[TB] frames during copy");
    r0 = rd_rises;
    pulse_frame();
    pulse_vblank();
    step(4);
    n_checks++; if (state_dbg !== 3'd3) begin n_fail++; $display("[TB] FAIL fdc_copy: got %0d expected 3", state_dbg); end
    repeat (3) begin
      pulse_frame();
      step(1);
    end
    n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("[TB] FAIL fdc_drop3: got %0d expected 3", drop_cnt); end
    for (int i = 0; i < 200 && state_dbg !== 3'd4; i++) step(1);
    n_checks++; if (state_dbg !== 3'd4) begin n_fail++; $display("[TB] FAIL fdc_reach_gap: got %0d expected 4", state_dbg); end
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL fdc_frame_cnt: got %0d expected 2", frame_cnt); end
    step(3);
    // frame on the GAP-to-IDLE cycle: dropped, does not arm
    pulse_frame();
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("[TB] FAIL fdc_gap_exit_no_arm: got %0d expected 0", state_dbg); end
    n_checks++; if (drop_cnt !== 8'd4) begin n_fail++; $display("[TB] FAIL fdc_gap_exit_drop: got %0d expected 4", drop_cnt); end
    step(5);
    n_checks++; if (rd_rises - r0 !== 1) begin n_fail++; $display("[TB] FAIL fdc_single_rd: got %0d expected 1", rd_rises - r0); end
  endtask

  task automatic test_disable();
    int r0;
    $display("[TB] disable while armed / during copy");
    r0 = rd_rises;
    pulse_frame();
    n_checks++; if (state_dbg !== 3'd1) begin n_fail++; $display("[TB] FAIL dis_armed: got %0d expected 1", state_dbg); end
    enable = 1'b0;
    step(1);
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("[TB] FAIL dis_back_idle: got %0d expected 0", state_dbg); end
    vga_vblank = 1'b1;
    step(2);
    vga_vblank = 1'b0;
    pulse_frame();
    step(1);
    n_checks++; if (state_dbg !== 3'd0 || drop_cnt !== 8'd4) begin n_fail++; $display("[TB] FAIL dis_idle_ignore: got state %0d drop %0d expected 0/4", state_dbg, drop_cnt); end
    n_checks++; if (rd_rises - r0 !== 0) begin n_fail++; $display("[TB] FAIL dis_no_rd: got %0d expected 0", rd_rises - r0); end
    enable = 1'b1;
    pulse_frame();
    pulse_vblank();
    step(4);
    n_checks++; if (state_dbg !== 3'd3) begin n_fail++; $display("[TB] FAIL dis_copy: got %0d expected 3", state_dbg); end
    enable = 1'b0;
    for (int i = 0; i < 200 && state_dbg !== 3'd4; i++) step(1);
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL dis_copy_completes: got %0d expected 3", frame_cnt); end
    for (int i = 0; i < 20 && state_dbg !== 3'd0; i++) step(1);
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("[TB] FAIL dis_end_idle: got %0d expected 0", state_dbg); end
    enable = 1'b1;
  endtask

  task automatic test_start_timeout();
    $display("[TB] unresponsive buffer");
    buf_mode = 1;
    pulse_frame();
    pulse_vblank();
    n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("[TB] FAIL sto_start: got %0d expected 2", state_dbg); end
    step(7);
    n_checks++; if (state_dbg !== 3'd2 || bif.buf_r_rd !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL sto_before: got state %0d rd %0d err %0d expected 2/1/0", state_dbg, bif.buf_r_rd, err_timeout); end
    step(1);
    n_checks++; if (state_dbg !== 3'd4 || bif.buf_r_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL sto_gap: got state %0d rd %0d expected 4/0", state_dbg, bif.buf_r_rd); end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL sto_err: got %0d expected 1", err_timeout); end
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL sto_frame_cnt: got %0d expected 3", frame_cnt); end
    step(4);
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("[TB] FAIL sto_idle: got %0d expected 0", state_dbg); end
    step(5);
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL sto_sticky: got %0d expected 1", err_timeout); end
  endtask

  task automatic test_reset_mid_copy();
    $display("[TB] reset mid copy");
    buf_mode = 2;
    pulse_frame();
    pulse_vblank();
    step(4);
    n_checks++; if (state_dbg !== 3'd3) begin n_fail++; $display("[TB] FAIL rmc_copy: got %0d expected 3", state_dbg); end
    pulse_frame();
    n_checks++; if (drop_cnt !== 8'd5) begin n_fail++; $display("[TB] FAIL rmc_drop_pre: got %0d expected 5", drop_cnt); end
    rst = 1'b1;
    #2;
    n_checks++; if (state_dbg !== 3'd0 || bif.buf_r_rd !== 1'b0 || copy_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rmc_async_state: got state %0d rd %0d busy %0d expected 0/0/0", state_dbg, bif.buf_r_rd, copy_busy); end
    n_checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 8'd0 || err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rmc_async_cnt: got frame %0d drop %0d err %0d expected 0/0/0", frame_cnt, drop_cnt, err_timeout); end
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_copy_stall();
    $display("[TB] copy stall");
    buf_mode = 2;
    pulse_frame();
    pulse_vblank();
    step(4);
    n_checks++; if (state_dbg !== 3'd3) begin n_fail++; $display("[TB] FAIL stall_copy: got %0d expected 3", state_dbg); end
`ifdef FRAME_COPY_SCHED_TIMEOUT_EN
    step(99);
    n_checks++; if (state_dbg !== 3'd3 || bif.buf_r_rd !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_before: got state %0d rd %0d err %0d expected 3/1/0", state_dbg, bif.buf_r_rd, err_timeout); end
    step(1);
    n_checks++; if (state_dbg !== 3'd4 || bif.buf_r_rd !== 1'b0 || err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_timeout: got state %0d rd %0d err %0d expected 4/0/1", state_dbg, bif.buf_r_rd, err_timeout); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL stall_frame_cnt: got %0d expected 0", frame_cnt); end
`else
    step(300);
    n_checks++; if (state_dbg !== 3'd3 || bif.buf_r_rd !== 1'b1 || copy_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_waits: got state %0d rd %0d busy %0d expected 3/1/1", state_dbg, bif.buf_r_rd, copy_busy); end
    n_checks++; if (err_timeout !== 1'b0 || frame_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL stall_no_err: got err %0d frame %0d expected 0/0", err_timeout, frame_cnt); end
`endif
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_drop_saturation();
    $display("[TB] drop counter saturation");
    buf_mode = 0;
    pulse_frame();
    repeat (254) begin
      pulse_frame();
      step(1);
    end
    n_checks++; if (drop_cnt !== 8'd254) begin n_fail++; $display("[TB] FAIL sat_254: got %0d expected 254", drop_cnt); end
    pulse_frame();
    step(1);
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_255: got %0d expected 255", drop_cnt); end
    repeat (45) begin
      pulse_frame();
      step(1);
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d expected 255", drop_cnt); end
    n_checks++; if (state_dbg !== 3'd1) begin n_fail++; $display("[TB] FAIL sat_state: got %0d expected 1", state_dbg); end
  endtask

  initial begin
    test_reset();
    test_nominal_copy();
    test_frame_during_copy();
    test_disable();
    test_start_timeout();
    test_reset_mid_copy();
    test_copy_stall();
    test_drop_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
